// File: rtl/unidade_controle.sv
// rtl/unidade_controle.sv - multicycle control FSM for the 64-bit datapath
module unidade_controle #(
    parameter int CNT_W     = 16,
    parameter int MAX_INSTR = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [6:0]       opcode,
    output logic             pc_en,
    output logic             ir_en,
    output logic             reg_we,
    output logic             dmem_we,
    output logic             sel_imm,
    output logic             sel_wb,
    output logic [1:0]       alu_op,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_FETCH   = 4'd1;
    localparam logic [3:0] S_LOAD_IR = 4'd2;
    localparam logic [3:0] S_DECODE  = 4'd3;
    localparam logic [3:0] S_EXEC    = 4'd4;
    localparam logic [3:0] S_MEM_RD  = 4'd5;
    localparam logic [3:0] S_MEM_WR  = 4'd6;
    localparam logic [3:0] S_WB      = 4'd7;
    localparam logic [3:0] S_HALT    = 4'd8;

    localparam logic [6:0] OP_HALT  = 7'b0000000;
    localparam logic [6:0] OP_LOAD  = 7'b0000001;
    localparam logic [6:0] OP_STORE = 7'b0000010;
    localparam logic [6:0] OP_ADD   = 7'b0000011;
    localparam logic [6:0] OP_SUB   = 7'b0000100;
    localparam logic [6:0] OP_ADDI  = 7'b0000101;
    localparam logic [6:0] OP_SUBI  = 7'b0000110;

    localparam logic [CNT_W-1:0] MAX_L   = CNT_W'(MAX_INSTR);
    localparam bit               LIMITED = (MAX_INSTR != 0);

    logic [3:0]       state;
    logic [3:0]       state_nxt;
    logic [6:0]       op_q;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             op_known;
    logic             retire;
    logic             limit_hit;
    logic             exec_sub;
    logic             exec_imm;

    // Classify the live IR opcode; only consulted while in DECODE.
    always_comb begin
        op_known = 1'b0;
        case (opcode)
            OP_HALT, OP_LOAD, OP_STORE, OP_ADD,
            OP_SUB, OP_ADDI, OP_SUBI: op_known = 1'b1;
            default:                  op_known = 1'b0;
        endcase
    end

    assign retire    = (state == S_MEM_WR) || (state == S_WB);
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign limit_hit = LIMITED && (cnt_inc == MAX_L);

    // Execute-phase selects come from the latched opcode so they stay stable through MEM/WB.
    assign exec_sub = (op_q == OP_SUB) || (op_q == OP_SUBI);
    assign exec_imm = (op_q == OP_LOAD) || (op_q == OP_STORE) ||
                      (op_q == OP_ADDI) || (op_q == OP_SUBI);

    // Next-state selection; every non-idle, non-halt state lasts exactly one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    state_nxt = start ? S_FETCH : S_IDLE;
            S_FETCH:   state_nxt = S_LOAD_IR;
            S_LOAD_IR: state_nxt = S_DECODE;
            S_DECODE: begin
                if (!op_known || opcode == OP_HALT)
                    state_nxt = S_HALT;
                else
                    state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (op_q == OP_LOAD)
                    state_nxt = S_MEM_RD;
                else if (op_q == OP_STORE)
                    state_nxt = S_MEM_WR;
                else
                    state_nxt = S_WB;
            end
            S_MEM_RD:  state_nxt = S_WB;
            S_MEM_WR:  state_nxt = limit_hit ? S_HALT : S_FETCH;
            S_WB:      state_nxt = limit_hit ? S_HALT : S_FETCH;
            S_HALT:    state_nxt = S_HALT;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // State register; async reset abandons any in-flight instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Opcode latch and sticky illegal flag, both updated only in DECODE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_HALT;
            illegal_q <= 1'b0;
        end else if (state == S_DECODE) begin
            op_q <= opcode;
            if (!op_known)
                illegal_q <= 1'b1;
        end
    end

    // Retired-instruction counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (retire)
            cnt_q <= cnt_inc;
    end

    // Moore output decode from state and latched opcode.
    always_comb begin
        pc_en   = 1'b0;
        ir_en   = 1'b0;
        reg_we  = 1'b0;
        dmem_we = 1'b0;
        sel_imm = 1'b1;
        sel_wb  = 1'b1;
        alu_op  = 2'b00;
        case (state)
            S_LOAD_IR: begin
                ir_en = 1'b1;
                pc_en = 1'b1;
            end
            S_EXEC, S_MEM_RD: begin
                sel_imm = ~exec_imm;
                alu_op  = exec_sub ? 2'b01 : 2'b00;
            end
            S_MEM_WR: begin
                sel_imm = ~exec_imm;
                alu_op  = exec_sub ? 2'b01 : 2'b00;
                dmem_we = 1'b1;
            end
            S_WB: begin
                sel_imm = ~exec_imm;
                alu_op  = exec_sub ? 2'b01 : 2'b00;
                reg_we  = 1'b1;
                sel_wb  = (op_q != OP_LOAD);
            end
            default: ;
        endcase
    end

    assign busy      = (state != S_IDLE) && (state != S_HALT);
    assign halted    = (state == S_HALT);
    assign illegal   = illegal_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_unidade_controle.sv
// tb/tb_unidade_controle.sv - scoreboard bench for unidade_controle
module tb_unidade_controle;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [6:0] opcode;

    logic       pc_en, ir_en, reg_we, dmem_we, sel_imm, sel_wb, busy, halted, illegal;
    logic [1:0] alu_op;
    logic [1:0] instr_cnt;

    logic       l_pc_en, l_ir_en, l_reg_we, l_dmem_we, l_sel_imm, l_sel_wb, l_busy, l_halted, l_illegal;
    logic [1:0] l_alu_op;
    logic [1:0] l_instr_cnt;

    always #5 clk = ~clk;

    unidade_controle #(.CNT_W(2), .MAX_INSTR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .pc_en(pc_en), .ir_en(ir_en), .reg_we(reg_we), .dmem_we(dmem_we),
        .sel_imm(sel_imm), .sel_wb(sel_wb), .alu_op(alu_op), .busy(busy),
        .halted(halted), .illegal(illegal), .instr_cnt(instr_cnt)
    );

    unidade_controle #(.CNT_W(2), .MAX_INSTR(3)) dut_lim (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .pc_en(l_pc_en), .ir_en(l_ir_en), .reg_we(l_reg_we), .dmem_we(l_dmem_we),
        .sel_imm(l_sel_imm), .sel_wb(l_sel_wb), .alu_op(l_alu_op), .busy(l_busy),
        .halted(l_halted), .illegal(l_illegal), .instr_cnt(l_instr_cnt)
    );

    localparam logic [6:0] OP_HALT  = 7'b0000000;
    localparam logic [6:0] OP_LOAD  = 7'b0000001;
    localparam logic [6:0] OP_STORE = 7'b0000010;
    localparam logic [6:0] OP_ADD   = 7'b0000011;
    localparam logic [6:0] OP_SUB   = 7'b0000100;
    localparam logic [6:0] OP_ADDI  = 7'b0000101;
    localparam logic [6:0] OP_SUBI  = 7'b0000110;

    // kind: 0 = register writeback, 1 = load, 2 = store
    typedef struct {
        string      name;
        logic [6:0] op;
        int         kind;
        logic       exp_imm;
        logic [1:0] exp_alu;
        logic       exp_wb;
    } vec_t;

    typedef struct {
        logic [12:0] w;
        string       tag;
    } exp_t;

    vec_t  vecs[6];
    exp_t  q[$];
    int    passed = 0;
    int    total  = 0;
    logic       exp_ill;
    logic [1:0] exp_cnt;

    // word layout: pc ir we dwe imm wb alu[1:0] busy halted illegal cnt[1:0]
    function automatic logic [12:0] act_main();
        return {pc_en, ir_en, reg_we, dmem_we, sel_imm, sel_wb, alu_op, busy, halted, illegal, instr_cnt};
    endfunction

    function automatic logic [12:0] act_lim();
        return {l_pc_en, l_ir_en, l_reg_we, l_dmem_we, l_sel_imm, l_sel_wb, l_alu_op, l_busy, l_halted, l_illegal, l_instr_cnt};
    endfunction

    function automatic logic [12:0] w(input logic pc, input logic ir, input logic we, input logic dwe,
                                      input logic imm, input logic wb, input logic [1:0] alu,
                                      input logic bsy, input logic hlt);
        return {pc, ir, we, dwe, imm, wb, alu, bsy, hlt, exp_ill, exp_cnt};
    endfunction

    task automatic chk(input string tag, input logic [12:0] act, input logic [12:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b required %b", tag, act, exp);
    endtask

    task automatic push(input logic [12:0] word, input string tag);
        exp_t e;
        e.w = word;
        e.tag = tag;
        q.push_back(e);
    endtask

    // One expected word per cycle from FETCH to the retiring state.
    task automatic push_instr(input vec_t v);
        push(w(0,0,0,0,1,1,2'b00,1,0), {v.name, " FETCH"});
        push(w(1,1,0,0,1,1,2'b00,1,0), {v.name, " LOAD_IR"});
        push(w(0,0,0,0,1,1,2'b00,1,0), {v.name, " DECODE"});
        push(w(0,0,0,0,v.exp_imm,1,v.exp_alu,1,0), {v.name, " EXEC"});
        if (v.kind == 1) begin
            push(w(0,0,0,0,v.exp_imm,1,v.exp_alu,1,0), {v.name, " MEM_RD"});
            push(w(0,0,1,0,v.exp_imm,v.exp_wb,v.exp_alu,1,0), {v.name, " WB"});
        end else if (v.kind == 2) begin
            push(w(0,0,0,1,v.exp_imm,1,v.exp_alu,1,0), {v.name, " MEM_WR"});
        end else begin
            push(w(0,0,1,0,v.exp_imm,v.exp_wb,v.exp_alu,1,0), {v.name, " WB"});
        end
        exp_cnt = exp_cnt + 2'd1;
    endtask

    task automatic run(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                total++;
                $display("FAIL scoreboard: queue empty, got %b required an entry", act_main());
            end else begin
                e = q.pop_front();
                chk(e.tag, act_main(), e.w);
            end
        end
    endtask

    task automatic exec(input vec_t v);
        opcode = v.op;
        push_instr(v);
        run(q.size());
    endtask

    task automatic do_reset(input logic s);
        rst_n = 1'b0;
        start = s;
        opcode = OP_HALT;
        exp_cnt = 2'd0;
        exp_ill = 1'b0;
        q.delete();
        repeat (2) @(negedge clk);
        chk("reset", act_main(), w(0,0,0,0,1,1,2'b00,0,0));
        chk("reset lim", act_lim(), w(0,0,0,0,1,1,2'b00,0,0));
        rst_n = 1'b1;
    endtask

    function automatic vec_t find(input logic [6:0] op);
        vec_t r;
        r = vecs[0];
        for (int i = 0; i < 6; i++)
            if (vecs[i].op == op) r = vecs[i];
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        vecs[0] = '{"LOAD",  OP_LOAD,  1, 1'b0, 2'b00, 1'b0};
        vecs[1] = '{"STORE", OP_STORE, 2, 1'b0, 2'b00, 1'b1};
        vecs[2] = '{"ADD",   OP_ADD,   0, 1'b1, 2'b00, 1'b1};
        vecs[3] = '{"SUB",   OP_SUB,   0, 1'b1, 2'b01, 1'b1};
        vecs[4] = '{"ADDI",  OP_ADDI,  0, 1'b0, 2'b00, 1'b1};
        vecs[5] = '{"SUBI",  OP_SUBI,  0, 1'b0, 2'b01, 1'b1};

        // Reset with start held high, then ADD, LOAD, STORE, SUBI, SUB.
        do_reset(1'b1);
        exec(find(OP_ADD));
        exec(find(OP_LOAD));
        exec(find(OP_STORE));
        exec(find(OP_SUBI));
        exec(find(OP_SUB));

        // Whole table, wrapping the 2-bit counter along the way.
        for (int i = 0; i < 6; i++) exec(vecs[i]);

        // IDLE holds while start is low.
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) push(w(0,0,0,0,1,1,2'b00,0,0), "IDLE hold");
        run(3);
        start = 1'b1;
        exec(find(OP_ADDI));

        // HALT opcode: no illegal flag, start ignored afterwards.
        opcode = OP_HALT;
        push(w(0,0,0,0,1,1,2'b00,1,0), "HALT FETCH");
        push(w(1,1,0,0,1,1,2'b00,1,0), "HALT LOAD_IR");
        push(w(0,0,0,0,1,1,2'b00,1,0), "HALT DECODE");
        run(3);
        for (int i = 0; i < 5; i++) begin
            start = ~start;
            push(w(0,0,0,0,1,1,2'b00,0,1), "HALT stay");
            run(1);
        end

        // Illegal opcode: sticky flag, halted for 100 cycles while start toggles.
        do_reset(1'b1);
        exec(find(OP_SUB));
        opcode = 7'b1111111;
        push(w(0,0,0,0,1,1,2'b00,1,0), "ILL FETCH");
        push(w(1,1,0,0,1,1,2'b00,1,0), "ILL LOAD_IR");
        push(w(0,0,0,0,1,1,2'b00,1,0), "ILL DECODE");
        run(3);
        exp_ill = 1'b1;
        for (int i = 0; i < 100; i++) begin
            start = ~start;
            push(w(0,0,0,0,1,1,2'b00,0,1), "ILL halt");
            run(1);
        end

        // Async reset in the middle of MEM_WR.
        do_reset(1'b1);
        exec(find(OP_ADD));
        opcode = OP_STORE;
        push_instr(find(OP_STORE));
        run(5);
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 2'd0;
        exp_ill = 1'b0;
        q.delete();
        chk("async dmem_we", {12'd0, dmem_we}, 13'd0);
        chk("async reset", act_main(), w(0,0,0,0,1,1,2'b00,0,0));
        @(negedge clk);
        chk("held reset", act_main(), w(0,0,0,0,1,1,2'b00,0,0));
        rst_n = 1'b1;
        exec(find(OP_ADD));

        // Counter wrap 1,2,3,0,1 and retire limit on the second instance.
        do_reset(1'b1);
        exec(find(OP_ADD));
        exec(find(OP_ADD));
        chk("lim running", act_lim(), {4'b0010, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 2'd1});
        exec(find(OP_ADD));
        opcode = OP_ADD;
        push_instr(find(OP_ADD));
        run(1);
        chk("lim halted", act_lim(), {4'b0000, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 2'd3});
        run(q.size());
        exec(find(OP_ADD));
        chk("lim stays", act_lim(), {4'b0000, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 2'd3});
        push(w(0,0,0,0,1,1,2'b00,1,0), "wrap FETCH");
        run(1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
